// File: rtl/aes_pkg.sv
// Shared constants for the AES known-answer self-test sequencer: mode codes,
// round counts, FIPS-197 test vectors, FSM states and the wait-window helper.
package aes_pkg;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    localparam int NR_128_DEF = 10;
    localparam int NR_192_DEF = 12;
    localparam int NR_256_DEF = 14;

    localparam logic [127:0] PT_VEC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ENC_WAIT  = 3'd1,
        S_ENC_CHECK = 3'd2,
        S_DEC_WAIT  = 3'd3,
        S_DEC_CHECK = 3'd4,
        S_DONE      = 3'd5
    } seq_state_e;

    // Cycles to wait for a core result: round count plus output latency margin.
    function automatic logic [4:0] wait_cycles(input logic [1:0] m, input int nr128,
                                               input int nr192, input int nr256,
                                               input int margin);
        int nr;
        case (m)
            MODE_192: nr = nr192;
            MODE_256: nr = nr256;
            default:  nr = nr128;
        endcase
        return 5'(nr + margin);
    endfunction

    function automatic logic [127:0] expected_ct(input logic [1:0] m);
        case (m)
            MODE_192: return CT_192;
            MODE_256: return CT_256;
            default:  return CT_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_seq_timer.sv
// Loadable 5-bit down-counter; o_expire is high for the single cycle in which
// the count sits at 1, so a load of N gives exactly N cycles before the pulse.
module aes_seq_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [4:0] i_load_val,
    output logic       o_expire
);

    logic [4:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= 5'd0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != 5'd0)
            r_cnt <= r_cnt - 5'd1;
    end

    assign o_expire = (r_cnt == 5'd1);

endmodule

// File: rtl/aes_selftest_seq.sv
// AES known-answer self-test sequencer: encrypt, check, decrypt, check, report.
// Build option AES_SEQ_LOOP_EN: when defined, IDLE restarts a run every time.
module aes_selftest_seq
    import aes_pkg::*;
#(
    parameter int NR_128     = NR_128_DEF,
    parameter int NR_192     = NR_192_DEF,
    parameter int NR_256     = NR_256_DEF,
    parameter int LAT_MARGIN = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [127:0] cipher_out,
    input  logic [127:0] decipher_out,
    output logic         core_reset,
    output logic         dec_enable,
    output logic [127:0] dec_in,
    output logic [1:0]   sel_mode,
    output logic         show_plain,
    output logic [7:0]   disp_byte,
    output logic         busy,
    output logic         done,
    output logic         cipher_ok,
    output logic         decipher_ok,
    output logic         mode_err
);

    localparam logic [2:0] ST_IDLE      = S_IDLE;
    localparam logic [2:0] ST_ENC_WAIT  = S_ENC_WAIT;
    localparam logic [2:0] ST_ENC_CHECK = S_ENC_CHECK;
    localparam logic [2:0] ST_DEC_WAIT  = S_DEC_WAIT;
    localparam logic [2:0] ST_DEC_CHECK = S_DEC_CHECK;
    localparam logic [2:0] ST_DONE      = S_DONE;

    logic [2:0]   r_state;
    logic         r_core_reset, r_dec_enable, r_show_plain, r_busy, r_done;
    logic         r_cipher_ok, r_decipher_ok, r_mode_err;
    logic [127:0] r_dec_in;
    logic [1:0]   r_sel_mode;
    logic [7:0]   r_disp_byte;

    logic         w_go, w_legal, w_tmr_load, w_expire;
    logic [1:0]   w_tmr_mode;
    logic [4:0]   w_tmr_val;

`ifdef AES_SEQ_LOOP_EN
    assign w_go = 1'b1;
`else
    assign w_go = start;
`endif

    assign w_legal    = (mode != MODE_ILL);
    // The first window is sized from the live mode because sel_mode is latched on the same edge.
    assign w_tmr_mode = (r_state == ST_IDLE) ? mode : r_sel_mode;
    assign w_tmr_val  = wait_cycles(w_tmr_mode, NR_128, NR_192, NR_256, LAT_MARGIN);
    assign w_tmr_load = ((r_state == ST_IDLE) && w_go && w_legal) || (r_state == ST_ENC_CHECK);

    aes_seq_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_core_reset  <= 1'b1;
            r_dec_enable  <= 1'b0;
            r_dec_in      <= '0;
            r_sel_mode    <= 2'b00;
            r_show_plain  <= 1'b0;
            r_disp_byte   <= 8'h00;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cipher_ok   <= 1'b0;
            r_decipher_ok <= 1'b0;
            r_mode_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_sel_mode    <= mode;
                        r_cipher_ok   <= 1'b0;
                        r_decipher_ok <= 1'b0;
                        r_show_plain  <= 1'b0;
                        if (w_legal) begin
                            r_mode_err   <= 1'b0;
                            r_busy       <= 1'b1;
                            r_core_reset <= 1'b0;
                            r_state      <= ST_ENC_WAIT;
                        end else begin
                            r_mode_err <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_ENC_WAIT: if (w_expire) r_state <= ST_ENC_CHECK;
                ST_ENC_CHECK: begin
                    r_dec_in     <= cipher_out;
                    r_disp_byte  <= cipher_out[7:0];
                    r_cipher_ok  <= (cipher_out == expected_ct(r_sel_mode));
                    r_dec_enable <= 1'b1;
                    r_state      <= ST_DEC_WAIT;
                end
                ST_DEC_WAIT: if (w_expire) r_state <= ST_DEC_CHECK;
                ST_DEC_CHECK: begin
                    // Plaintext is checked even when the ciphertext was wrong.
                    r_disp_byte   <= decipher_out[7:0];
                    r_show_plain  <= 1'b1;
                    r_decipher_ok <= (decipher_out == PT_VEC);
                    r_done        <= 1'b1;
                    r_busy        <= 1'b0;
                    r_dec_enable  <= 1'b0;
                    r_core_reset  <= 1'b1;
                    r_state       <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign core_reset  = r_core_reset;
    assign dec_enable  = r_dec_enable;
    assign dec_in      = r_dec_in;
    assign sel_mode    = r_sel_mode;
    assign show_plain  = r_show_plain;
    assign disp_byte   = r_disp_byte;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cipher_ok   = r_cipher_ok;
    assign decipher_ok = r_decipher_ok;
    assign mode_err    = r_mode_err;

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Scoreboard bench for aes_selftest_seq: randomized runs against behavioural
// cipher/decipher core models, expected results queued per run.
module tb_aes_selftest_seq;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   mode;
    logic [127:0] cipher_out, decipher_out;
    logic         core_reset, dec_enable, show_plain, busy, done;
    logic         cipher_ok, decipher_ok, mode_err;
    logic [127:0] dec_in;
    logic [1:0]   sel_mode;
    logic [7:0]   disp_byte;

    aes_selftest_seq dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .cipher_out(cipher_out), .decipher_out(decipher_out),
        .core_reset(core_reset), .dec_enable(dec_enable), .dec_in(dec_in),
        .sel_mode(sel_mode), .show_plain(show_plain), .disp_byte(disp_byte),
        .busy(busy), .done(done), .cipher_ok(cipher_ok),
        .decipher_ok(decipher_ok), .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    function automatic logic [127:0] ref_ct(input logic [1:0] m);
        case (m)
            2'd0:    return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            2'd1:    return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            default: return 128'h8ea2b7ca516745bfeafc49904b496089;
        endcase
    endfunction

    function automatic int ref_w(input logic [1:0] m);
        case (m)
            2'd0:    return 10 + 2;
            2'd1:    return 12 + 2;
            default: return 14 + 2;
        endcase
    endfunction

    typedef struct {
        logic [1:0]   mode;
        bit           legal;
        bit           cok, dok;
        logic [127:0] dec_in;
        logic [7:0]   disp;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0, n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Core models: output is garbage until the core has run its full window.
    int         enc_cnt = 0, dec_cnt = 0;
    logic [1:0] run_mode = 2'd0;
    bit         bad_c = 1'b0, bad_d = 1'b0;

    always @(posedge clk) begin
        enc_cnt <= core_reset ? 0 : enc_cnt + 1;
        dec_cnt <= dec_enable ? dec_cnt + 1 : 0;
    end

    assign cipher_out   = (!core_reset && enc_cnt >= ref_w(run_mode))
                          ? (bad_c ? 128'd0 : ref_ct(run_mode)) : ~ref_ct(run_mode);
    assign decipher_out = (dec_enable && dec_cnt >= ref_w(run_mode))
                          ? (bad_d ? ~PT : PT) : ~PT;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic exp_t mk(input logic [1:0] m, input bit bc, input bit bd, input int idx);
        exp_t e;
        e.mode  = m;
        e.legal = (m != 2'd3);
        if (e.legal) begin
            e.cok      = !bc;
            e.dok      = !bd;
            e.dec_in   = bc ? 128'd0 : ref_ct(m);
            e.disp     = bd ? 8'h00 : 8'hff;
            e.done_cyc = idx + 2 * ref_w(m) + 2;
        end else begin
            e.cok      = 1'b0;
            e.dok      = 1'b0;
            e.dec_in   = 128'd0;
            e.disp     = 8'h00;
            e.done_cyc = idx;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    bit saw_crlow = 1'b0, saw_busy = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            saw_crlow = 1'b0;
            saw_busy  = 1'b0;
        end else begin
            if (!core_reset) saw_crlow = 1'b1;
            if (busy)        saw_busy  = 1'b1;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 128'(done), 128'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", 128'(cyc), 128'(e.done_cyc));
                    chk("flags", {cipher_ok, decipher_ok, mode_err}, {e.cok, e.dok, !e.legal});
                    chk("done_ctrl", {busy, core_reset, dec_enable}, 3'b010);
                    chk("core_released", 128'(saw_crlow), 128'(e.legal));
                    chk("busy_seen", 128'(saw_busy), 128'(e.legal));
                    if (e.legal) begin
                        chk("dec_in", dec_in, e.dec_in);
                        chk("disp_byte", 128'(disp_byte), 128'(e.disp));
                        chk("show_plain", 128'(show_plain), 128'd1);
                        chk("sel_mode", 128'(sel_mode), 128'(e.mode));
                    end
                end
                saw_crlow = 1'b0;
                saw_busy  = 1'b0;
            end
        end
    end

    task automatic wait_drain();
        int b = 0;
        while (sb.size() != 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 128'(sb.size()), 128'd0);
            sb.delete();
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_dec_in"}, dec_in, 128'd0);
        chk({tag, "_ctrl"}, 128'({core_reset, dec_enable, sel_mode, show_plain, disp_byte,
                                  busy, done, cipher_ok, decipher_ok, mode_err}),
            128'(18'h20000));
    endtask

    task automatic run(input logic [1:0] m, input bit bc, input bit bd);
        int idx;
        @(negedge clk);
        mode = m; start = 1'b1; run_mode = m; bad_c = bc; bad_d = bd;
        @(posedge clk); #1;
        idx = cyc;
        sb.push_back(mk(m, bc, bd, idx));
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int idx;
        reset = 1'b1; start = 1'b0; mode = 2'd0;
        repeat (3) @(negedge clk);
        chk_rst("reset");
`ifdef AES_SEQ_LOOP_EN
        reset = 1'b0; mode = 2'd0; run_mode = 2'd0;
        @(posedge clk); #1;
        idx = cyc;
        for (int k = 0; k < 4; k++) sb.push_back(mk(2'd0, 1'b0, 1'b0, idx + 28 * k));
        wait_drain();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_rst("loop_reset");
`else
        reset = 1'b0;
        @(negedge clk);
        // Directed cases.
        run(2'd0, 1'b0, 1'b0);
        run(2'd2, 1'b1, 1'b0);
        run(2'd3, 1'b0, 1'b0);

        // Mode change and start pulse during DEC_WAIT must be ignored.
        @(negedge clk);
        mode = 2'd1; start = 1'b1; run_mode = 2'd1; bad_c = 1'b0; bad_d = 1'b0;
        @(posedge clk); #1;
        idx = cyc;
        sb.push_back(mk(2'd1, 1'b0, 1'b0, idx));
        @(negedge clk);
        start = 1'b0;
        repeat (ref_w(2'd1) + 4) @(negedge clk);
        mode = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 2'd2;
        wait_drain();
        repeat (40) @(negedge clk);

        // Reset mid-run (with start held) wins and leaves nothing behind.
        @(negedge clk);
        mode = 2'd2; start = 1'b1; run_mode = 2'd2;
        @(posedge clk); #1;
        sb.push_back(mk(2'd2, 1'b0, 1'b0, cyc));
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        chk_rst("midrun_reset");
        sb.delete();
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        run(2'd2, 1'b0, 1'b0);

        // Back-to-back: start held across DONE.
        @(negedge clk);
        mode = 2'd0; start = 1'b1; run_mode = 2'd0; bad_c = 1'b0; bad_d = 1'b0;
        @(posedge clk); #1;
        idx = cyc;
        sb.push_back(mk(2'd0, 1'b0, 1'b0, idx));
        sb.push_back(mk(2'd0, 1'b0, 1'b0, idx + 2 * ref_w(2'd0) + 4));
        wait_drain();
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized runs.
        repeat (12) begin
            logic [1:0] m;
            bit bc, bd;
            m  = 2'($urandom_range(0, 3));
            bc = ($urandom_range(0, 3) == 0);
            bd = ($urandom_range(0, 3) == 0);
            run(m, bc, bd);
        end
        repeat (5) @(negedge clk);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
